// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

    localparam int WORD_W    = 32;
    localparam int HDR_BYTES = 4;

    typedef logic [$clog2(HDR_BYTES)-1:0] lane_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_CHK, ST_RUN, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_RUN, ST_ERR} state_t;
`endif

endpackage

// File: rtl/imem_loader_word_pack.sv
// Little-endian byte-to-word assembler shared by header, data and checksum words.
// The completed word is presented combinationally alongside the 4th byte.
module loader_word_pack
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    lane_t                lane_reg;
    logic [WORD_W-9:0]    shift_reg;

    // Bytes enter at the top and move down, so the first byte ends up in bits 7:0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_reg  <= '0;
            shift_reg <= '0;
        end else if (byte_en) begin
            lane_reg  <= lane_reg + 1'b1;
            shift_reg <= {byte_in, shift_reg[WORD_W-9:8]};
        end
    end

    assign word      = {byte_in, shift_reg};
    assign word_done = byte_en && (lane_reg == lane_t'(HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> sequential instruction-memory writes, then CPU release.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing sum-of-words checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_LOADED = ST_CHK;
`else
    localparam state_t ST_LOADED = ST_RUN;
`endif

    state_t            state_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   word_cnt_reg;
    logic              accept;
    logic              word_done;
    logic [WORD_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_reg;
`endif

    assign in_ready = !(state_reg == ST_RUN || state_reg == ST_ERR);
    assign accept   = in_valid && in_ready;
    assign error    = (state_reg == ST_ERR);

    loader_word_pack u_pack (
        .clk       (clk),
        .reset     (reset),
        .byte_en   (accept),
        .byte_in   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_HDR;
            count_reg    <= '0;
            word_cnt_reg <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= '0;
`endif
        end else begin
            imem_we   <= 1'b0;
            // Release lags RUN entry by one edge so the final write lands first.
            cpu_reset <= (state_reg != ST_RUN);
            done      <= (state_reg == ST_RUN);
            if (word_done) begin
                case (state_reg)
                    ST_HDR: begin
                        if (word == '0) begin
                            state_reg <= ST_LOADED;
                        end else if (word > WORD_W'(DEPTH)) begin
                            state_reg <= ST_ERR;
                        end else begin
                            count_reg    <= word[ADDR_W:0];
                            word_cnt_reg <= '0;
                            state_reg    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= word_cnt_reg[ADDR_W-1:0];
                        imem_wdata   <= word;
                        word_cnt_reg <= word_cnt_reg + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_reg      <= sum_reg + word;
`endif
                        if (word_cnt_reg + 1'b1 == count_reg)
                            state_reg <= ST_LOADED;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        state_reg <= (word == sum_reg) ? ST_RUN : ST_ERR;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (default build): expected writes are queued
// as words are streamed and compared as the write strobes appear.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img_q[$];
    wr_t         mon_e;
    int          n_checks = 0;
    int          n_errors = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
            if (exp_q.size() == 0) begin
                check("spurious_we", imem_we, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", imem_addr, mon_e.addr);
                check("wr_data", imem_wdata, mon_e.data);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, '0);
        check("rst_wdata", imem_wdata, '0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        #2;
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_vals();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input bit is_data,
                             input logic [ADDR_W-1:0] addr);
        wr_t e;
        if (is_data) begin
            e.addr = addr;
            e.data = w;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], gap);
        // Strobe must be up in the cycle right after the 4th byte's edge.
        check("we_after_byte3", imem_we, is_data);
    endtask

    task automatic load_image(input bit gap);
        send_word(32'(img_q.size()), gap, 1'b0, '0);
        for (int i = 0; i < img_q.size(); i++)
            send_word(img_q[i], gap, 1'b1, ADDR_W'(i));
    endtask

    task automatic check_run();
        check("run_in_ready", in_ready, 1'b0);
        check("run_cpu_reset_edge0", cpu_reset, 1'b1);
        check("run_done_edge0", done, 1'b0);
        @(posedge clk); #1;
        check("run_cpu_reset", cpu_reset, 1'b0);
        check("run_done", done, 1'b1);
        check("run_error", error, 1'b0);
        check("run_we_off", imem_we, 1'b0);
        check("run_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_vals();

        // Three-word program, back-to-back bytes
        img_q = '{32'h20080005, 32'h20090007, 32'h01095020};
        load_image(1'b0);
        check_run();

        // Same image with in_valid toggled every other cycle
        do_reset();
        load_image(1'b1);
        check_run();

        // Empty image
        do_reset();
        send_word(32'h0, 1'b0, 1'b0, '0);
        check_run();

        // Oversized image rejected
        do_reset();
        send_word(32'h101, 1'b0, 1'b0, '0);
        check("err_error", error, 1'b1);
        check("err_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++)
            send_byte(8'hA5, 1'b0);
        check("err_hold_error", error, 1'b1);
        check("err_cpu_reset", cpu_reset, 1'b1);
        check("err_done", done, 1'b0);
        check("err_in_ready_hold", in_ready, 1'b0);

        // Reset after 2 of 3 words, then full reload
        do_reset();
        send_word(32'd3, 1'b0, 1'b0, '0);
        send_word(img_q[0], 1'b0, 1'b1, 8'd0);
        send_word(img_q[1], 1'b0, 1'b1, 8'd1);
        @(negedge clk);
        do_reset();
        load_image(1'b0);
        check_run();

        // Full-depth image
        do_reset();
        img_q.delete();
        for (int i = 0; i < DEPTH; i++)
            img_q.push_back($urandom);
        load_image(1'b0);
        check_run();

        check("final_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
